// File: rtl/softplus_sched_if.sv
// Bundle between the requester lanes, the shared softplus unit and the result consumer.
// master = scheduler side, slave = everything around it.
interface softplus_sched_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_operand;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      sp_operand;
    logic [WIDTH-1:0]      sp_out;
    logic                  rsp_valid;
    logic [IDXW-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;
    logic                  busy;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // req_ready is a combinational grant, so requesters must not derive req_valid from it.
    modport master (
        input  req_valid, req_operand, sp_out, rsp_ready,
        output req_ready, sp_operand, rsp_valid, rsp_id, rsp_data, busy
    );
    modport slave (
        output req_valid, req_operand, sp_out, rsp_ready,
        input  req_ready, sp_operand, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/softplus_sched.sv
// Round-robin arbiter sharing one combinational softplus unit across NREQ lanes.
// Optional macro SOFTPLUS_RANGE_BYPASS_EN: operands outside [LO_LIM, HI_LIM] bypass the unit.
module softplus_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
`ifdef SOFTPLUS_RANGE_BYPASS_EN
    ,
    parameter logic [WIDTH-1:0] LO_LIM = 16'hF900,
    parameter logic [WIDTH-1:0] HI_LIM = 16'h0700
`endif
) (
    input  logic              clock,
    input  logic              rst,
    softplus_sched_if.master  bus,
    output logic [1:0]        fsm_state
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_reg, rsp_data_r, result;
    logic [IDXW-1:0]  id_reg, rr_ptr, rsp_id_r, win, ptr_next;
    logic [NREQ-1:0]  ready;
    logic             rsp_valid_r, found, can_grant, grant;
    int               idx;

    // Scan from rr_ptr upward, wrapping, so the last winner gets lowest priority next time.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IDXW'(idx);
            end
        end
        ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    always_comb begin
        state_next = state;
        can_grant  = 1'b0;
        case (state)
            IDLE: begin
                can_grant = 1'b1;
                if (found) state_next = EVAL;
            end
            EVAL: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    can_grant  = 1'b1;
                    state_next = found ? EVAL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        grant = can_grant && found;
        ready = '0;
        if (grant) ready[win] = 1'b1;
    end

`ifdef SOFTPLUS_RANGE_BYPASS_EN
    always_comb begin
        if ($signed(op_reg) > $signed(HI_LIM))      result = op_reg;
        else if ($signed(op_reg) < $signed(LO_LIM)) result = '0;
        else                                        result = bus.sp_out;
    end
`else
    assign result = bus.sp_out;
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            op_reg      <= '0;
            id_reg      <= '0;
            rr_ptr      <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                op_reg <= bus.req_operand[int'(win)*WIDTH +: WIDTH];
                id_reg <= win;
                rr_ptr <= ptr_next;
            end
            // Only the EVAL edge produces a result, so a RESP handshake always clears valid.
            if (state == EVAL) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= result;
                rsp_id_r    <= id_reg;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.sp_operand = op_reg;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.busy       = (state != IDLE);
    assign fsm_state      = state;
endmodule

// File: doc/softplus_sched.md
# softplus_sched

Round-robin scheduler that shares one combinational `softplus` unit (Q8.8, 16-bit signed) between `NREQ` requesting lanes of the VAE datapath. It registers the winning operand and drives the unit's `operand` port. It captures the unit's `out` one cycle later and returns the result with the requester index over a valid/ready response channel. It sits between the encoder variance lanes and the shared softplus instance.

## Interface
- `WIDTH`, 16: operand/result width, Q8.8 signed.
- `NREQ`, 4: number of requesters, 2..8; `IDXW = $clog2(NREQ)` is derived locally.
- `LO_LIM`, 16'hF900: lower edge of the softplus approximation range (-7.0).
- `HI_LIM`, 16'h0700: upper edge of the softplus approximation range (+7.0).
- `clock`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_operand`  in  NREQ*WIDTH  requester i operand at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot grant; high only on the accepting cycle.
- `sp_operand`  out  WIDTH  to softplus `operand`.
- `sp_out`  in  WIDTH  from softplus `out` (combinational).
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  IDXW  index of the requester that owns the result.
- `rsp_data`  out  WIDTH  softplus result.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in EVAL or RESP.

## Operation
- FSM states: IDLE, EVAL, RESP. Reset state is IDLE.
- Round-robin pointer `rr_ptr` (IDXW bits) resets to 0, so requester 0 has top priority after reset.
- **IDLE:** the winner is the first i with `req_valid[i]`, scanning from `rr_ptr` upward modulo NREQ.
  - `req_ready[i]=1` for the winner only, combinationally from `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - On the edge: `op_reg<=operand`, `id_reg<=i`, `rr_ptr<=(i+1)%NREQ`, state goes to EVAL.
  - With no valid request, stay in IDLE.
- **EVAL:** `sp_operand=op_reg`, held stable.
  - On the edge: `rsp_data<=result`, `rsp_id<=id_reg`, `rsp_valid<=1`, state goes to RESP.
  - No requests are granted in EVAL.
- **RESP:** `rsp_valid`, `rsp_id` and `rsp_data` are held until `rsp_ready`.
  - On `rsp_valid&&rsp_ready`, arbitration runs in the same cycle as in IDLE.
  - If a winner exists, it is accepted and the next state is EVAL (back-to-back).
  - If there is no winner, the next state is IDLE.
  - `rsp_valid` drops on the following edge unless that edge itself produces a new result.
- `sp_operand` holds `op_reg` in all states, so the operand is never glitched by arbitration.
- `result` is `sp_out` (see Configuration).
- A requester whose `req_valid` drops before it is granted is skipped; there is no queuing.
- **Reset mid-operation:** reset on any edge forces the following.
  - State returns to IDLE, `rsp_valid=0`, `rr_ptr=0`.
  - Any in-flight operand or result is discarded, and no response is emitted for it.

## Timing
- Reset values: `req_ready=0`, `sp_operand=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`.
- Latency: grant at edge N, `rsp_valid` high after edge N+1.
- Peak throughput is one result per 2 cycles, reached when `rsp_ready` is held high.
- The softplus path is combinational between two registers: `op_reg` to `rsp_data`, one cycle.

## Configuration
- `SOFTPLUS_RANGE_BYPASS_EN` defined: in EVAL, results outside the approximation range bypass the unit. Comparisons are signed.
  - `op_reg > HI_LIM` gives `result=op_reg` (softplus(x)≈x).
  - `op_reg < LO_LIM` gives `result=0`.
  - Otherwise `result=sp_out`.
- Not defined: `result=sp_out` for every operand.

## Test plan
- **Single request.** Stimulus: reset; requester 2 valid with operand 16'h0100; bench stub drives `sp_out=~sp_operand`.
  - `req_ready=4'b0100` for exactly one cycle.
  - `rsp_valid` is high 2 cycles later with `rsp_id=2` and `rsp_data=16'hFEFF`.
- **Round-robin fairness.** Stimulus: all four requesters hold valid with `rsp_ready=1`.
  - Grant order is 0,1,2,3,0.
  - Results arrive every 2 cycles with matching `rsp_id`.
- **Backpressure.** Stimulus: `rsp_ready=0` for 5 cycles after a result.
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable.
  - No `req_ready` is asserted until the handshake.
  - The next grant occurs on the handshake cycle.
- **Bypass.** Stimulus: operands 16'h0800, 16'hF800 and 16'h0000.
  - With `SOFTPLUS_RANGE_BYPASS_EN`: results are 16'h0800, 16'h0000, and `sp_out` for 16'h0000.
  - Without the macro: all three results equal `sp_out`.
- **Reset mid-operation.** Stimulus: assert `rst` in EVAL.
  - Next cycle: state is IDLE, `rsp_valid=0` and never rises for the dropped request, `sp_operand=0`.
  - The following grant goes to the lowest valid index.
